aes_round_sched: RTL
====================

AES_ROUND_SCHED -- requirements
Module: aes_round_sched

Interface
REQ-001 Parameter NR, default 10, SHALL set the number of AES rounds (AES-128).
REQ-002 Parameter TIMEOUT, default 15, SHALL set the maximum number of WAIT cycles allowed per round.
REQ-003 Parameter BLOCK_W, default 128, SHALL set the state width in bits, using the NB=4, WORD=8 column-major byte order.
REQ-004 The block SHALL use one clock and one reset; the reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 i_valid  input  1  plaintext block offered.
REQ-008 o_ready  output  1  scheduler can accept a block.
REQ-009 i_block  input  BLOCK_W  plaintext.
REQ-010 o_rk_idx  output  4  round-key index driven to the external key store.
REQ-011 i_rk  input  BLOCK_W  round key for o_rk_idx, combinational and valid in the same cycle.
REQ-012 o_dp_valid  output  1  issue the current state to the round datapath (SubBytes/ShiftRows/MixColumns).
REQ-013 o_dp_block  output  BLOCK_W  state sent to the datapath.
REQ-014 o_dp_last  output  1  final round; the datapath SHALL bypass MixColumns.
REQ-015 i_dp_valid  input  1  datapath result valid.
REQ-016 i_dp_block  input  BLOCK_W  datapath result, before AddRoundKey.
REQ-017 o_valid  output  1  ciphertext available.
REQ-018 i_ready  input  1  downstream accepts the ciphertext.
REQ-019 o_block  output  BLOCK_W  ciphertext.
REQ-020 o_err  output  1  sticky error flag: timeout or unexpected datapath response.

Function
REQ-021 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT and DONE.
REQ-022 IDLE behaviour:
- o_ready=1 and o_rk_idx=0.
- On i_valid&&o_ready: state_reg<=i_block^i_rk, round<=1, wdog<=0, next state ISSUE.
REQ-023 ISSUE behaviour:
- o_dp_valid=1 for exactly one cycle, with o_dp_block=state_reg and o_dp_last=(round==NR).
- Next state is WAIT unconditionally.
REQ-024 WAIT behaviour:
- o_rk_idx=round.
- On i_dp_valid: state_reg<=i_dp_block^i_rk.
- If round==NR, next state is DONE; otherwise round<=round+1 and next state is ISSUE.
REQ-025 In ISSUE and WAIT, o_rk_idx SHALL equal round.
REQ-026 round SHALL be 4 bits, count 1..NR, and never wrap; reaching NR in WAIT with i_dp_valid SHALL always exit to DONE.
REQ-027 DONE behaviour:
- o_valid=1 and o_block=state_reg, held stable until i_ready.
- On i_valid&&... no: on o_valid&&i_ready, next state is IDLE.
- o_ready=0 while in DONE; back-to-back acceptance SHALL first be possible in the cycle after the DONE handshake.
REQ-028 The wdog counter SHALL increment every WAIT cycle without i_dp_valid; when wdog==TIMEOUT, the block SHALL set o_err=1 and go to IDLE, dropping the block.
REQ-029 i_dp_valid in any state other than WAIT SHALL be ignored for data and SHALL set o_err=1.
REQ-030 o_err SHALL clear only on reset.
REQ-031 o_ready SHALL be 1 only in IDLE.
REQ-032 o_dp_valid SHALL be 1 only in ISSUE.
REQ-033 o_valid SHALL be 1 only in DONE.
REQ-034 With datapath latency L cycles, o_valid SHALL rise NR*(L+1) cycles after the acceptance edge; for L=1 this is 20 cycles.
REQ-035 i_valid or i_block changes while the block is busy SHALL have no effect on the block in flight.

Reset
REQ-036 While rst_n=0, all of the following SHALL be forced: state=IDLE; round, wdog, state_reg and o_block all zero; o_valid, o_dp_valid and o_err at 0; o_ready at 1; o_rk_idx at 0.
REQ-037 Reset asserted mid-operation SHALL abort the block immediately with no output produced, and a late i_dp_valid after reset release SHALL set o_err.

Structure
REQ-038 Package aes_pkg SHALL hold NB, WORD, BLOCK_W, NR and the FSM state enum (IDLE, ISSUE, WAIT, DONE).
REQ-039 The block SHALL be flat, with no sub-module: the round datapath and key store are external and connected through the dp/rk ports.
REQ-040 Only state_reg, round, wdog, the FSM and o_err SHALL be registered; all other outputs SHALL be decoded from the FSM state.

Verification
REQ-041 FIPS-197 vector: key 000102030405060708090a0b0c0d0e0f and plaintext 00112233445566778899aabbccddeeff, with a 1-cycle datapath model, SHALL give o_block=69c4e0d86a7b0430d8cdb78070b4c55a and o_valid exactly 20 cycles after acceptance.
REQ-042 A datapath with L=3 SHALL produce the same ciphertext with o_valid 40 cycles after acceptance, and o_dp_last=1 only in the round-10 issue.
REQ-043 With i_ready held low for 7 cycles in DONE, o_block SHALL stay stable and o_ready=0; the next block SHALL be accepted in the cycle after the i_ready handshake.
REQ-044 With i_dp_valid withheld in round 4, o_err SHALL go to 1 after 15 WAIT cycles, the FSM SHALL return to IDLE, and o_valid SHALL never assert.
REQ-045 A spurious i_dp_valid in IDLE SHALL set o_err=1 and leave state_reg unchanged.
REQ-046 rst_n pulsed low during round 6 SHALL force all outputs to their reset values; a fresh FIPS vector after release SHALL pass with o_err=0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants and FSM encoding for the AES round scheduler.
// A 128-bit block is held column-major: byte i = block[127-8*i -: 8],
// row = i % NB, column = i / NB.
package aes_pkg;

    localparam int NB      = 4;
    localparam int WORD    = 8;
    localparam int BLOCK_W = NB * NB * WORD;
    localparam int NR      = 10;

    // Scheduler states: accept, hand a round to the datapath, await it, present result
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } aes_state_e;

endpackage

// File: rtl/aes_round_sched.sv
// AES encryption round scheduler. Holds the running state, walks the round
// counter, fetches round keys from an external key store and hands each round
// to an external SubBytes/ShiftRows/MixColumns datapath. AddRoundKey is done
// here on the datapath result. A watchdog drops a block whose datapath never
// answers; any protocol breach latches a sticky error.
module aes_round_sched
    import aes_pkg::*;
#(
    parameter int NR      = aes_pkg::NR,
    parameter int TIMEOUT = 15,
    parameter int BLOCK_W = aes_pkg::BLOCK_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [BLOCK_W-1:0] i_block,
    output logic [3:0]         o_rk_idx,
    input  logic [BLOCK_W-1:0] i_rk,
    output logic               o_dp_valid,
    output logic [BLOCK_W-1:0] o_dp_block,
    output logic               o_dp_last,
    input  logic               i_dp_valid,
    input  logic [BLOCK_W-1:0] i_dp_block,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [BLOCK_W-1:0] o_block,
    output logic               o_err
);

    localparam int                WDOG_W    = $clog2(TIMEOUT + 1);
    localparam logic [3:0]        NR_L      = 4'(NR);
    localparam logic [WDOG_W-1:0] TIMEOUT_L = WDOG_W'(TIMEOUT);
    localparam logic [WDOG_W-1:0] WDOG_ONE  = {{(WDOG_W-1){1'b0}}, 1'b1};

    aes_state_e          state_r;
    aes_state_e          state_s;
    logic [BLOCK_W-1:0]  data_r;
    logic [3:0]          round_r;
    logic [WDOG_W-1:0]   wdog_r;
    logic                err_r;

    logic [WDOG_W-1:0]   wdog_inc_s;
    logic                last_round_s;
    logic                timeout_s;

    // The watchdog trips on the WAIT cycle that would bring the count to
    // TIMEOUT, so at most TIMEOUT silent WAIT cycles are tolerated per round.
    assign wdog_inc_s   = wdog_r + WDOG_ONE;
    assign timeout_s    = (wdog_inc_s == TIMEOUT_L);
    assign last_round_s = (round_r == NR_L);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_valid) begin
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                state_s = WAIT;
            end
            WAIT: begin
                if (i_dp_valid) begin
                    if (last_round_s) begin
                        state_s = DONE;
                    end else begin
                        state_s = ISSUE;
                    end
                end else if (timeout_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Running state, round counter and watchdog; data only moves in IDLE and WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r  <= '0;
            round_r <= 4'd0;
            wdog_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (i_valid) begin
                        data_r  <= i_block ^ i_rk;
                        round_r <= 4'd1;
                        wdog_r  <= '0;
                    end
                end
                WAIT: begin
                    if (i_dp_valid) begin
                        data_r <= i_dp_block ^ i_rk;
                        wdog_r <= '0;
                        if (!last_round_s) begin
                            round_r <= round_r + 4'd1;
                        end
                    end else begin
                        wdog_r <= wdog_inc_s;
                    end
                end
                default: begin
                    data_r <= data_r;
                end
            endcase
        end
    end

    // Sticky error: datapath answer outside WAIT, or watchdog expiry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if ((state_r != WAIT) && i_dp_valid) begin
            err_r <= 1'b1;
        end else if ((state_r == WAIT) && !i_dp_valid && timeout_s) begin
            err_r <= 1'b1;
        end
    end

    // Output decode from the FSM state
    always_comb begin
        o_ready    = 1'b0;
        o_dp_valid = 1'b0;
        o_dp_last  = 1'b0;
        o_valid    = 1'b0;
        o_rk_idx   = 4'd0;
        o_block    = '0;
        case (state_r)
            IDLE: begin
                o_ready = 1'b1;
            end
            ISSUE: begin
                o_dp_valid = 1'b1;
                o_dp_last  = last_round_s;
                o_rk_idx   = round_r;
            end
            WAIT: begin
                o_rk_idx = round_r;
            end
            DONE: begin
                o_valid = 1'b1;
                o_block = data_r;
            end
            default: begin
                o_ready = 1'b0;
            end
        endcase
    end

    assign o_dp_block = data_r;
    assign o_err      = err_r;

endmodule
